iwdg_rst_ctrl: RTL
==================

// Module: iwdg_rst_ctrl
// PURPOSE
//  Downstream consumer of the IWDG reset pulse (rst_iwdg, clk_lsi domain).
//  Synchronises it into clk_m2s and turns each event into a fixed-width system reset pulse.
//  Records reset cause in sticky flags and a reset counter, readable over a Wishbone slave.
//  Also accepts a software reset request.
// PARAMETERS
//  RST_PULSE_CYCLES  16                  sys_rst_n low time, clk_m2s cycles (>=1)
//  HOLDOFF_CYCLES    8                   post-pulse window; new events are not re-triggered (>=1)
//  CNT_W             8                   reset counter width
//  BASE_ADR          32'h0100_0100       register base address
//  CSR_ADR           BASE_ADR+32'h0      control/status register
//  CNT_ADR           BASE_ADR+32'h4      watchdog reset counter
// PORTS
//  clk_m2s       in   1   Wishbone/system clock; the only clock
//  rst_m2s       in   1   asynchronous, active-low reset
//  rst_iwdg_lsi  in   1   IWDG reset pulse, clk_lsi domain; high >=1 clk_lsi cycle
//  dat_m2s       in   16  Wishbone write data
//  adr_m2s       in   32  Wishbone address
//  cyc_m2s       in   1   Wishbone cycle valid
//  we_m2s        in   1   Wishbone write enable
//  stb_m2s       in   1   Wishbone strobe
//  dat_s2m       out  16  Wishbone read data, registered
//  ack_s2m       out  1   Wishbone acknowledge, registered, 1-cycle pulse
//  sys_rst_n     out  1   system reset, active-low, registered
//  rst_active    out  1   high while FSM is not IDLE
// BEHAVIOUR
//  Reset (rst_m2s=0, async):
//   - FSM=IDLE, sys_rst_n=1, rst_active=0, ack_s2m=0, dat_s2m=0, IWDGRSTF=SFTRSTF=0, PORRSTF=1, CNT=0.
//   - Sync flops clear. Reset mid-pulse aborts at once; no residual pulse.
//  Sync:
//   - rst_iwdg_lsi passes 2 flops, then a registered rising-edge detect -> iwdg_evt (1 cycle).
//   - Requires f(clk_m2s) >= 2*f(clk_lsi).
//   - If sampled high at edge k, iwdg_evt is high after edge k+2 and sys_rst_n falls at edge k+3.
//  CSR (16b):
//   - [0] IWDGRSTF  R, sticky
//   - [1] SFTRSTF   R, sticky
//   - [2] PORRSTF   R, sticky
//   - [3] RMVF      W1, clears [2:0] and CNT; reads 0
//   - [8] SWRST     W1, sw_evt; reads 0
//   - [15] BUSY     = rst_active
//   - other bits read 0
//  CNT: [CNT_W-1:0] count of iwdg_evt that launched ASSERT; saturates at all-ones; zero-extended to 16b.
//  FSM:
//   - IDLE: on iwdg_evt|sw_evt -> ASSERT, cnt=RST_PULSE_CYCLES-1.
//   - ASSERT: sys_rst_n=0; decrement cnt; at 0 -> HOLDOFF, cnt=HOLDOFF_CYCLES-1.
//   - HOLDOFF: sys_rst_n=1; decrement; at 0 -> IDLE.
//   - Events in ASSERT/HOLDOFF set their flag only: no retrigger, no CNT increment.
//  Simultaneous events:
//   - iwdg_evt+sw_evt: both flags set, one pulse, CNT+1.
//   - RMVF with an event in the same cycle: clear first, then the event applies (flag=1, CNT=1 if it launched).
//   - RMVF with SWRST in the same write: clear, then SFTRSTF=1.
//  Wishbone:
//   - cyc&stb high with ack_s2m low -> ack_s2m=1 on the next edge with dat_s2m, then 0 for >=1 cycle.
//   - Writes take effect on the ack edge.
//   - Unmapped address: read 0, write ignored, still acked.
//   - dat_s2m=0 when not acking.
// CONFIGURATION
//  IWDG_RST_COUNT_EN defined:
//   - CNT register and counter implemented as above.
//  IWDG_RST_COUNT_EN undefined:
//   - No counter logic; CNT_ADR reads 0 and writes are ignored (still acked).
//   - All other behaviour unchanged.
// TESTING
//  1. Release reset, read CSR -> 16'h0004 and CNT -> 0; sys_rst_n=1 throughout.
//  2. rst_iwdg_lsi high 1 clk_lsi cycle -> sys_rst_n low exactly 16 cycles, 3 edges after sample;
//     CSR=16'h0005, CNT=1.
//  3. Second IWDG pulse during HOLDOFF -> no new pulse; CSR[0]=1; CNT stays 1.
//  4. Write CSR=16'h0100 -> 16-cycle pulse, SFTRSTF=1; then write 16'h0008 -> CSR=0, CNT=0.
//  5. 255 IWDG events with CNT_W=8, then 1 more -> CNT=255 (saturated).
//  6. Assert rst_m2s at pulse cycle 5 -> sys_rst_n=1 immediately; after release CSR=16'h0004;
//     read of 0x0100_0010 -> 0 with ack.

Source files
------------

// File: rtl/iwdg_rst_ctrl.sv
// IWDG reset consumer: syncs rst_iwdg_lsi, stretches events into a fixed sys_rst_n pulse,
// keeps sticky cause flags. Define IWDG_RST_COUNT_EN to build the watchdog reset counter.
module iwdg_rst_ctrl #(
    parameter int          RST_PULSE_CYCLES = 16,
    parameter int          HOLDOFF_CYCLES   = 8,
    parameter int          CNT_W            = 8,
    parameter logic [31:0] BASE_ADR         = 32'h0100_0100
) (
    input  logic        clk_m2s,
    input  logic        rst_m2s,
    input  logic        rst_iwdg_lsi,
    input  logic [15:0] dat_m2s,
    input  logic [31:0] adr_m2s,
    input  logic        cyc_m2s,
    input  logic        we_m2s,
    input  logic        stb_m2s,
    output logic [15:0] dat_s2m,
    output logic        ack_s2m,
    output logic        sys_rst_n,
    output logic        rst_active
);
    localparam logic [31:0] CSR_ADR = BASE_ADR + 32'h0;
    localparam logic [31:0] CNT_ADR = BASE_ADR + 32'h4;
    localparam int TMAX = (RST_PULSE_CYCLES > HOLDOFF_CYCLES) ? RST_PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_HOLD} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic          launch;
    logic [2:0]    sync;
    logic          iwdg_evt;
    logic          iwdg_f, sft_f, por_f;
    logic          wb_req, wr_csr, rmvf, sw_evt;
    logic [15:0]   rdata, cnt_rd;
    logic          unused_dat;

    assign unused_dat = ^{dat_m2s[15:9], dat_m2s[7:4], dat_m2s[2:0]};

    // Two-flop synchroniser plus a registered rising-edge detect.
    always_ff @(posedge clk_m2s or negedge rst_m2s) begin
        if (!rst_m2s) begin
            sync     <= '0;
            iwdg_evt <= 1'b0;
        end else begin
            sync     <= {sync[1:0], rst_iwdg_lsi};
            iwdg_evt <= sync[1] & ~sync[2];
        end
    end

    assign wb_req = cyc_m2s & stb_m2s & ~ack_s2m;
    assign wr_csr = wb_req & we_m2s & (adr_m2s == CSR_ADR);
    assign rmvf   = wr_csr & dat_m2s[3];
    assign sw_evt = wr_csr & dat_m2s[8];

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        launch    = 1'b0;
        case (state)
            ST_IDLE: if (iwdg_evt | sw_evt) begin
                state_nxt = ST_ASSERT;
                tmr_nxt   = TW'(RST_PULSE_CYCLES - 1);
                launch    = 1'b1;
            end
            ST_ASSERT: if (tmr == '0) begin
                state_nxt = ST_HOLD;
                tmr_nxt   = TW'(HOLDOFF_CYCLES - 1);
            end else begin
                tmr_nxt = tmr - 1'b1;
            end
            ST_HOLD: if (tmr == '0) state_nxt = ST_IDLE;
                     else           tmr_nxt   = tmr - 1'b1;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // sys_rst_n is registered off the next state so it moves on the same edge as the FSM.
    always_ff @(posedge clk_m2s or negedge rst_m2s) begin
        if (!rst_m2s) begin
            state     <= ST_IDLE;
            tmr       <= '0;
            sys_rst_n <= 1'b1;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            sys_rst_n <= (state_nxt != ST_ASSERT);
        end
    end

    assign rst_active = (state != ST_IDLE);

    // RMVF clears before same-cycle events are recorded.
    always_ff @(posedge clk_m2s or negedge rst_m2s) begin
        if (!rst_m2s) begin
            iwdg_f <= 1'b0;
            sft_f  <= 1'b0;
            por_f  <= 1'b1;
        end else begin
            iwdg_f <= (iwdg_f & ~rmvf) | iwdg_evt;
            sft_f  <= (sft_f & ~rmvf) | sw_evt;
            por_f  <= por_f & ~rmvf;
        end
    end

`ifdef IWDG_RST_COUNT_EN
    logic [CNT_W-1:0] rst_cnt, cnt_base;

    assign cnt_base = rmvf ? '0 : rst_cnt;

    always_ff @(posedge clk_m2s or negedge rst_m2s) begin
        if (!rst_m2s)
            rst_cnt <= '0;
        else if (launch && iwdg_evt && !(&cnt_base))
            rst_cnt <= cnt_base + 1'b1;
        else
            rst_cnt <= cnt_base;
    end

    assign cnt_rd = 16'(rst_cnt);
`else
    logic unused_launch;
    assign unused_launch = launch;
    assign cnt_rd        = '0;
`endif

    always_comb begin
        rdata = '0;
        if (adr_m2s == CSR_ADR)      rdata = {rst_active, 12'b0, por_f, sft_f, iwdg_f};
        else if (adr_m2s == CNT_ADR) rdata = cnt_rd;
    end

    always_ff @(posedge clk_m2s or negedge rst_m2s) begin
        if (!rst_m2s) begin
            ack_s2m <= 1'b0;
            dat_s2m <= '0;
        end else begin
            ack_s2m <= wb_req;
            dat_s2m <= (wb_req && !we_m2s) ? rdata : '0;
        end
    end
endmodule
